// File: rtl/press_pkg.sv
// press_pkg: shared state encoding and event-count width for press_classifier
package press_pkg;
  typedef enum logic [2:0] {IDLE, PRESSED, LONG_HELD, WAIT_SECOND, SECOND_PRESSED} press_state_t;
  localparam int EVT_W = 8;
endpackage

// File: rtl/edge_detect.sv
// edge_detect: registers the previous level and flags rising/falling edges
module edge_detect #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk_in,
  input  logic rst_in,
  input  logic level,
  output logic rise,
  output logic fall
);
  logic prev;
  always_ff @(posedge clk_in)
    prev <= rst_in ? RST_VAL : level;
  assign rise = level & ~prev;
  assign fall = ~level & prev;
endmodule

// File: rtl/press_classifier.sv
// press_classifier: short/long/double-click pulses from a debounced level; double click built with PRESS_CLASSIFIER_DOUBLE_EN
module press_classifier
  import press_pkg::*;
#(
  parameter int LONG_CYCLES = 50_000_000,
  parameter int GAP_CYCLES  = 25_000_000,
  parameter int CNT_W       = 27
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             clean_in,
  output logic             short_out,
  output logic             long_out,
  output logic             double_out,
  output logic             held_out,
  output logic [EVT_W-1:0] event_count_out
);
  press_state_t state;
  logic [CNT_W-1:0] cnt;
  logic rise, fall;
  logic [EVT_W-1:0] evt_inc;
  assign evt_inc = event_count_out + 1'b1;
  // prev resets high so a button held through reset must be seen low first
  edge_detect #(.RST_VAL(1'b1)) u_edge (
    .clk_in (clk_in),
    .rst_in (rst_in),
    .level  (clean_in),
    .rise   (rise),
    .fall   (fall)
  );
`ifndef PRESS_CLASSIFIER_DOUBLE_EN
  assign double_out = 1'b0;
`endif
  always_ff @(posedge clk_in)
    if (rst_in) begin
      state           <= IDLE;
      cnt             <= '0;
      short_out       <= 1'b0;
      long_out        <= 1'b0;
      held_out        <= 1'b0;
      event_count_out <= '0;
`ifdef PRESS_CLASSIFIER_DOUBLE_EN
      double_out      <= 1'b0;
`endif
    end else begin
      short_out <= 1'b0;
      long_out  <= 1'b0;
`ifdef PRESS_CLASSIFIER_DOUBLE_EN
      double_out <= 1'b0;
`endif
      cnt <= (state == PRESSED || state == WAIT_SECOND) ? cnt + 1'b1 : cnt;
      case (state)
        IDLE:
          if (rise) begin
            state <= PRESSED;
            cnt   <= '0;
          end
        PRESSED:
          if (fall) begin
            cnt <= '0;
`ifdef PRESS_CLASSIFIER_DOUBLE_EN
            state <= WAIT_SECOND;
`else
            state           <= IDLE;
            short_out       <= 1'b1;
            event_count_out <= evt_inc;
`endif
          end else if (cnt == CNT_W'(LONG_CYCLES - 1)) begin
            state           <= LONG_HELD;
            cnt             <= '0;
            long_out        <= 1'b1;
            held_out        <= 1'b1;
            event_count_out <= evt_inc;
          end
        LONG_HELD:
          if (fall) begin
            state    <= IDLE;
            cnt      <= '0;
            held_out <= 1'b0;
          end
`ifdef PRESS_CLASSIFIER_DOUBLE_EN
        WAIT_SECOND:
          if (rise) begin
            state <= SECOND_PRESSED;
            cnt   <= '0;
          end else if (cnt == CNT_W'(GAP_CYCLES - 1)) begin
            state           <= IDLE;
            cnt             <= '0;
            short_out       <= 1'b1;
            event_count_out <= evt_inc;
          end
        SECOND_PRESSED:
          if (fall) begin
            state           <= IDLE;
            cnt             <= '0;
            double_out      <= 1'b1;
            event_count_out <= evt_inc;
          end
`endif
        default: begin
          state <= IDLE;
          cnt   <= '0;
        end
      endcase
    end
endmodule

// File: tb/tb_press_classifier.sv
// tb_press_classifier: random press/release segments checked against a timestamp-based event model
module tb_press_classifier;
  localparam int LONG = 8;
  localparam int GAP  = 4;
  localparam int MAXC = 4096;
  logic clk_in = 1'b0, rst_in = 1'b1, clean_in = 1'b0;
  logic short_out, long_out, double_out, held_out;
  logic [7:0] event_count_out;
  int total = 0, bad = 0;
  int n_t = 0, pend_f = 0;
  bit pend = 0;
  bit stim [MAXC];
  bit e_s [MAXC];
  bit e_l [MAXC];
  bit e_d [MAXC];
  bit e_h [MAXC];
  press_classifier #(.LONG_CYCLES(LONG), .GAP_CYCLES(GAP), .CNT_W(4)) dut (
    .clk_in          (clk_in),
    .rst_in          (rst_in),
    .clean_in        (clean_in),
    .short_out       (short_out),
    .long_out        (long_out),
    .double_out      (double_out),
    .held_out        (held_out),
    .event_count_out (event_count_out)
  );
  always #5 clk_in = ~clk_in;
  task automatic chk(string tag, int cyc, logic [7:0] obs, logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s cyc=%0d observed=%0d expected=%0d", tag, cyc, obs, exp);
    end
  endtask
  // A press of h high edges starting at t0, then l low edges; events derived from timestamps
  task automatic add_seg(int h, int l);
    int t0 = n_t;
    int f = n_t + h;
    for (int i = 0; i < h; i++) stim[n_t++] = 1'b1;
    for (int i = 0; i < l; i++) stim[n_t++] = 1'b0;
`ifdef PRESS_CLASSIFIER_DOUBLE_EN
    if (pend && t0 - pend_f <= GAP) begin
      e_d[f] = 1'b1;
      pend = 1'b0;
      return;
    end
    if (pend) begin
      e_s[pend_f + GAP] = 1'b1;
      pend = 1'b0;
    end
`endif
    if (h > LONG) begin
      e_l[t0 + LONG] = 1'b1;
      for (int k = t0 + LONG; k < f; k++) e_h[k] = 1'b1;
    end else begin
`ifdef PRESS_CLASSIFIER_DOUBLE_EN
      pend = 1'b1;
      pend_f = f;
`else
      e_s[f] = 1'b1;
`endif
    end
  endtask
  initial begin
    int c;
    int ns, nd;
    n_t = 2;
    add_seg(3, 2);
    add_seg(9, 3);
    add_seg(3, 2);
    add_seg(2, 6);
    add_seg(3, 6);
    add_seg(8, 3);
    for (int i = 0; i < 60; i++) add_seg(int'($urandom_range(1, 12)), int'($urandom_range(1, 7)));
    for (int i = 0; i < 256; i++) add_seg(1, GAP + 2);
    for (int i = 0; i < GAP + 3; i++) stim[n_t++] = 1'b0;
    if (pend) e_s[pend_f + GAP] = 1'b1;
    repeat (2) @(posedge clk_in);
    #1;
    chk("rst_short", -1, 8'(short_out), 8'd0);
    chk("rst_long", -1, 8'(long_out), 8'd0);
    chk("rst_double", -1, 8'(double_out), 8'd0);
    chk("rst_held", -1, 8'(held_out), 8'd0);
    chk("rst_count", -1, event_count_out, 8'd0);
    rst_in = 1'b0;
    c = 0;
    for (int n = 0; n < n_t; n++) begin
      clean_in = stim[n];
      @(posedge clk_in);
      #1;
      c += int'(e_s[n]) + int'(e_l[n]) + int'(e_d[n]);
      chk("short", n, 8'(short_out), 8'(e_s[n]));
      chk("long", n, 8'(long_out), 8'(e_l[n]));
      chk("double", n, 8'(double_out), 8'(e_d[n]));
      chk("held", n, 8'(held_out), 8'(e_h[n]));
      chk("count", n, event_count_out, 8'(c % 256));
    end
    clean_in = 1'b1;
    rst_in = 1'b1;
    repeat (2) @(posedge clk_in);
    #1;
    rst_in = 1'b0;
    for (int n = 0; n < 20; n++) begin
      @(posedge clk_in);
      #1;
      chk("hold_rst_pulse", n, 8'({short_out, long_out, double_out, held_out}), 8'd0);
      chk("hold_rst_count", n, event_count_out, 8'd0);
    end
    clean_in = 1'b0;
    @(posedge clk_in);
    #1;
    clean_in = 1'b1;
    repeat (3) @(posedge clk_in);
    #1;
    clean_in = 1'b0;
    ns = 0;
    nd = 0;
    for (int n = 0; n < GAP + 3; n++) begin
      @(posedge clk_in);
      #1;
      ns += int'(short_out);
      nd += int'(double_out);
      chk("hold_rst_long", n, 8'(long_out), 8'd0);
    end
    chk("hold_rst_nshort", 0, 8'(ns), 8'd1);
    chk("hold_rst_ndouble", 0, 8'(nd), 8'd0);
    chk("hold_rst_evt", 0, event_count_out, 8'd1);
    repeat (2) @(posedge clk_in);
    #1;
    clean_in = 1'b1;
    repeat (5) @(posedge clk_in);
    #1;
    rst_in = 1'b1;
    @(posedge clk_in);
    #1;
    rst_in = 1'b0;
    chk("midrst_pulse", 0, 8'({short_out, long_out, double_out, held_out}), 8'd0);
    chk("midrst_count", 0, event_count_out, 8'd0);
    repeat (2) @(posedge clk_in);
    #1;
    clean_in = 1'b0;
    for (int n = 0; n < 12; n++) begin
      @(posedge clk_in);
      #1;
      chk("midrst_rel_pulse", n, 8'({short_out, long_out, double_out, held_out}), 8'd0);
      chk("midrst_rel_count", n, event_count_out, 8'd0);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
